// File: rtl/sound_cmd_pkg.sv
// Shared types and defaults for the 68k-to-Z80 sound command latch.
package sound_cmd_pkg;

  localparam int CMD_DW         = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_ACK    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/sound_cmd_fifo.sv
// Small command queue; head entry is presented combinationally, pop advances it.
module sound_cmd_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // A push into a full queue is accepted when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sound_cmd_latch.sv
// Z80-side sound command latch with interrupt handshake.
// Define SNDLATCH_FIFO_EN to replace the single overwrite latch with a queue.
module sound_cmd_latch
  import sound_cmd_pkg::*;
#(
  parameter int DW          = CMD_DW,
  parameter int INT_TIMEOUT = 0,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          SNDDT,
  input  logic          SNDON,
  input  logic [DW-1:0] cpu_data,
  input  logic          z80_cs_n,
  input  logic          z80_rd_n,
  input  logic          z80_iorq_n,
  input  logic          z80_m1_n,
  output logic [DW-1:0] z80_dout,
  output logic          z80_int_n,
  output logic          cmd_pending,
  output logic          overrun
);

  localparam int TW = (INT_TIMEOUT > 0) ? $clog2(INT_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(INT_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic          snddt_q, snddt_prev_q, sndon_q, sndon_prev_q;
  logic [DW-1:0] data_q;
  logic          cs_n_q, rd_n_q, iorq_n_q, m1_n_q, rd_act_prev_q;
  logic          rd_act, cap, done, irq_req;
  logic          ovr_q, ovr_d;

  irq_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // SNDON history resets high so a level already present out of reset is not an edge.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      snddt_q       <= 1'b1;
      snddt_prev_q  <= 1'b1;
      sndon_q       <= 1'b1;
      sndon_prev_q  <= 1'b1;
      data_q        <= '0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      iorq_n_q      <= 1'b1;
      m1_n_q        <= 1'b1;
      rd_act_prev_q <= 1'b0;
      ovr_q         <= 1'b0;
      state_q       <= IRQ_IDLE;
      tmo_q         <= '0;
    end else begin
      snddt_q       <= SNDDT;
      snddt_prev_q  <= snddt_q;
      sndon_q       <= SNDON;
      sndon_prev_q  <= sndon_q;
      data_q        <= cpu_data;
      cs_n_q        <= z80_cs_n;
      rd_n_q        <= z80_rd_n;
      iorq_n_q      <= z80_iorq_n;
      m1_n_q        <= z80_m1_n;
      rd_act_prev_q <= rd_act;
      ovr_q         <= ovr_d;
      state_q       <= state_d;
      tmo_q         <= tmo_d;
    end
  end

  assign rd_act  = !cs_n_q && !rd_n_q;
  assign cap     = snddt_prev_q && !snddt_q;
  assign done    = rd_act_prev_q && !rd_act;
  assign irq_req = sndon_q && !sndon_prev_q;

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    z80_int_n = 1'b1;
    unique case (state_q)
      IRQ_IDLE: begin
        if (irq_req) state_d = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        z80_int_n = 1'b0;
        tmo_d     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
        if (!iorq_n_q && !m1_n_q)
          state_d = IRQ_ACK;
        else if (INT_TIMEOUT != 0 && tmo_q == TMO_LAST)
          state_d = IRQ_IDLE;
      end
      IRQ_ACK: begin
        if (iorq_n_q) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

`ifdef SNDLATCH_FIFO_EN
  logic          q_full, q_empty, q_pop;
  logic [DW-1:0] q_head;

  assign q_pop = done && !q_empty;

  sound_cmd_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_main),
    .rst_i   (reset),
    .push_i  (cap),
    .wdata_i (data_q),
    .pop_i   (q_pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

  assign ovr_d       = ovr_q || (cap && q_full && !q_pop);
  assign cmd_pending = !q_empty;
  assign z80_dout    = q_empty ? '0 : q_head;
`else
  logic [DW-1:0] cmd_q, cmd_d;
  logic          pend_q, pend_d;

  // Read completion is applied before the capture, so a coincident write is not an overrun.
  always_comb begin
    cmd_d  = cmd_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (done) pend_d = 1'b0;
    if (cap) begin
      if (pend_q && !done) ovr_d = 1'b1;
      cmd_d  = data_q;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      cmd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      pend_q <= pend_d;
    end
  end

  assign cmd_pending = pend_q;
  assign z80_dout    = cmd_q;
`endif

  assign overrun = ovr_q;

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Directed bench for sound_cmd_latch with a 16-clock interrupt timeout.
module tb_sound_cmd_latch;
  import sound_cmd_pkg::*;

  logic       clk_main = 1'b0;
  logic       reset, SNDDT, SNDON;
  logic [7:0] cpu_data;
  logic       z80_cs_n, z80_rd_n, z80_iorq_n, z80_m1_n;
  logic [7:0] z80_dout;
  logic       z80_int_n, cmd_pending, overrun;

  int checks = 0;
  int errors = 0;
  int low_cnt, first_low;

  always #5 clk_main = ~clk_main;

  sound_cmd_latch #(.DW(8), .INT_TIMEOUT(16), .FIFO_DEPTH(4)) dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .SNDDT       (SNDDT),
    .SNDON       (SNDON),
    .cpu_data    (cpu_data),
    .z80_cs_n    (z80_cs_n),
    .z80_rd_n    (z80_rd_n),
    .z80_iorq_n  (z80_iorq_n),
    .z80_m1_n    (z80_m1_n),
    .z80_dout    (z80_dout),
    .z80_int_n   (z80_int_n),
    .cmd_pending (cmd_pending),
    .overrun     (overrun)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_main);
      @(negedge clk_main);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    cpu_data = d;
    SNDDT = 1'b0;
    cyc(2);
    SNDDT = 1'b1;
    cyc(2);
  endtask

  task automatic rd();
    z80_cs_n = 1'b0;
    z80_rd_n = 1'b0;
    cyc(2);
    z80_cs_n = 1'b1;
    z80_rd_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1; SNDDT = 1'b1; SNDON = 1'b1; cpu_data = 8'h00;
    z80_cs_n = 1'b1; z80_rd_n = 1'b1; z80_iorq_n = 1'b1; z80_m1_n = 1'b1;
    @(negedge clk_main);
    cyc(3);
    reset = 1'b0;
    cyc(5);

    // 1: reset state with SNDON already high
    chk("rst_int_n",   z80_int_n,   1);
    chk("rst_pending", cmd_pending, 0);
    chk("rst_dout",    z80_dout,    8'h00);
    chk("rst_overrun", overrun,     0);

    // 2: capture latency, single capture for a long strobe, IRQ handshake
    cpu_data = 8'h5A;
    SNDDT = 1'b0;
    cyc(1);
    chk("cap_lat1_pending", cmd_pending, 0);
    cyc(1);
    chk("cap_dout",    z80_dout,    8'h5A);
    chk("cap_pending", cmd_pending, 1);
    cyc(1);
    SNDDT = 1'b1;
    cpu_data = 8'hFF;
    cyc(2);
    chk("cap_once_overrun", overrun, 0);
    chk("cap_hold_dout",    z80_dout, 8'h5A);
    SNDON = 1'b0;
    cyc(2);
    SNDON = 1'b1;
    cyc(1);
    chk("irq_lat1", z80_int_n, 1);
    cyc(1);
    chk("irq_lat2", z80_int_n, 0);
    z80_iorq_n = 1'b0; z80_m1_n = 1'b0;
    cyc(1);
    chk("ack_lat1", z80_int_n, 0);
    cyc(1);
    chk("ack_int_n", z80_int_n, 1);
    chk("ack_state", 32'(dut.state_q), 32'(IRQ_ACK));
    z80_iorq_n = 1'b1; z80_m1_n = 1'b1;
    cyc(2);
    chk("ack_idle", 32'(dut.state_q), 32'(IRQ_IDLE));

    // 3: Z80 read; completion is seen once the release is registered
    z80_cs_n = 1'b0; z80_rd_n = 1'b0;
    cyc(4);
    chk("rd_dout",    z80_dout,    8'h5A);
    chk("rd_pending", cmd_pending, 1);
    z80_cs_n = 1'b1; z80_rd_n = 1'b1;
    cyc(1);
    chk("rd_rel_reg_pending", cmd_pending, 1);
    cyc(1);
    chk("rd_done_pending", cmd_pending, 0);
    chk("rd_overrun",      overrun,     0);

    // 4: two unread writes
    wr(8'h11);
    wr(8'h22);
`ifdef SNDLATCH_FIFO_EN
    chk("q_head_11",    z80_dout, 8'h11);
    chk("q_overrun0",   overrun,  0);
    wr(8'h33);
    wr(8'h44);
    chk("q_full_ovr0",  overrun,  0);
    wr(8'h55);
    chk("q_drop_ovr1",  overrun,  1);
    chk("q_drop_head",  z80_dout, 8'h11);
    rd();
    chk("q_head_22",    z80_dout, 8'h22);
`else
    chk("ovw_dout",    z80_dout,    8'h22);
    chk("ovw_overrun", overrun,     1);
    chk("ovw_pending", cmd_pending, 1);
`endif

    // 5: timeout of 16 clocks; a second SNDON edge while asserted does not extend it
    SNDON = 1'b0;
    cyc(1);
    SNDON = 1'b1;
    low_cnt = 0;
    first_low = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) SNDON = 1'b0;
      if (i == 7) SNDON = 1'b1;
      cyc(1);
      if (z80_int_n === 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = i;
      end
    end
    chk("tmo_first_low", first_low, 2);
    chk("tmo_low_clks",  low_cnt,   16);
    chk("tmo_int_n",     z80_int_n, 1);
    chk("tmo_idle",      32'(dut.state_q), 32'(IRQ_IDLE));

    // 6: reset while asserted with a pending command
    wr(8'h77);
    SNDON = 1'b0;
    cyc(1);
    SNDON = 1'b1;
    cyc(2);
    chk("mid_int_n_low", z80_int_n,   0);
    chk("mid_pending",   cmd_pending, 1);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_int_n",   z80_int_n,   1);
    chk("mid_rst_pending", cmd_pending, 0);
    chk("mid_rst_overrun", overrun,     0);
    chk("mid_rst_dout",    z80_dout,    8'h00);
    reset = 1'b0;
    cyc(2);

    // 6b: capture and read completion registered in the same cycle
    wr(8'h12);
    z80_cs_n = 1'b0; z80_rd_n = 1'b0;
    cyc(3);
    cpu_data = 8'h34;
    SNDDT = 1'b0;
    z80_cs_n = 1'b1; z80_rd_n = 1'b1;
    cyc(2);
    chk("sim_pending", cmd_pending, 1);
    chk("sim_dout",    z80_dout,    8'h34);
    chk("sim_overrun", overrun,     0);
    SNDDT = 1'b1;
    cyc(2);
    chk("sim_overrun_late", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
